// File: rtl/inst_fetch.sv
// Instruction fetch stage: PC register, RUN/WAIT memory handshake FSM and the
// IF/ID pipeline register, with branch redirect taking priority over stalls.
module inst_fetch #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] NOP_INST = 16'h0800
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] pc,
  input  logic [15:0] inst,
  input  logic        mem_ready,
  input  logic        stall,
  input  logic        branch_en,
  input  logic [15:0] branch_target,
  output logic [15:0] id_pc,
  output logic [15:0] id_inst,
  output logic        id_valid
);

  typedef enum logic {
    RUN  = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] id_pc_q, id_pc_d;
  logic [15:0] id_inst_q, id_inst_d;
  logic        id_valid_q, id_valid_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      id_pc_q    <= 16'h0000;
      id_inst_q  <= NOP_INST;
      id_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      id_pc_q    <= id_pc_d;
      id_inst_q  <= id_inst_d;
      id_valid_q <= id_valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    id_pc_d    = id_pc_q;
    id_inst_d  = id_inst_q;
    id_valid_d = id_valid_q;

    if (branch_en) begin
      // Redirect drops any outstanding fetch; the FSM restarts cleanly in RUN.
      state_d    = RUN;
      pc_d       = branch_target;
      id_pc_d    = pc_q;
      id_inst_d  = NOP_INST;
      id_valid_d = 1'b0;
    end else if (!stall) begin
      if (mem_ready) begin
        state_d    = RUN;
        pc_d       = pc_q + 16'h0001;
        id_pc_d    = pc_q;
        id_inst_d  = inst;
        id_valid_d = 1'b1;
      end else begin
        state_d    = WAIT;
        id_inst_d  = NOP_INST;
        id_valid_d = 1'b0;
      end
    end
  end

  assign pc       = pc_q;
  assign id_pc    = id_pc_q;
  assign id_inst  = id_inst_q;
  assign id_valid = id_valid_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed table-driven bench for inst_fetch with a combinational instruction
// memory model; each vector gives inputs for one edge and the expected outputs after it.
module tb_inst_fetch;

  localparam logic [15:0] NOP = 16'h0800;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] pc;
  logic [15:0] inst;
  logic        mem_ready;
  logic        stall;
  logic        branch_en;
  logic [15:0] branch_target;
  logic [15:0] id_pc;
  logic [15:0] id_inst;
  logic        id_valid;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  inst_fetch #(.RESET_PC(16'h0000), .NOP_INST(NOP)) dut (
    .clk(clk), .rst(rst), .pc(pc), .inst(inst), .mem_ready(mem_ready),
    .stall(stall), .branch_en(branch_en), .branch_target(branch_target),
    .id_pc(id_pc), .id_inst(id_inst), .id_valid(id_valid)
  );

  function automatic logic [15:0] memf(input logic [15:0] a);
    return {a[7:0] ^ 8'hC3, a[15:8] ^ 8'h5A};
  endfunction

  assign inst = memf(pc);

  typedef struct {
    logic        rst;
    logic        mr;
    logic        st;
    logic        br;
    logic [15:0] tgt;
    logic [15:0] e_pc;
    logic [15:0] e_id_pc;
    logic        e_v;
    logic        chk_id_pc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic m, input logic s, input logic b,
                     input logic [15:0] t, input logic [15:0] epc,
                     input logic [15:0] eidpc, input logic ev, input logic cidpc);
    vec_t v;
    v.rst = r; v.mr = m; v.st = s; v.br = b; v.tgt = t;
    v.e_pc = epc; v.e_id_pc = eidpc; v.e_v = ev; v.chk_id_pc = cidpc;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input string tag, input logic r, input logic m, input logic s,
                      input logic b, input logic [15:0] t, input logic [15:0] epc,
                      input logic [15:0] eidpc, input logic ev, input logic cidpc);
    logic [15:0] e_inst;
    @(negedge clk);
    rst = r; mem_ready = m; stall = s; branch_en = b; branch_target = t;
    @(posedge clk);
    #1;
    e_inst = ev ? memf(eidpc) : NOP;
    chk({tag, " pc"}, pc, epc);
    if (cidpc) chk({tag, " id_pc"}, id_pc, eidpc);
    chk({tag, " id_inst"}, id_inst, e_inst);
    chk({tag, " id_valid"}, {15'd0, id_valid}, {15'd0, ev});
    $display("%s rst=%0b mr=%0b st=%0b br=%0b tgt=%h -> pc=%h id_pc=%h id_inst=%h id_valid=%0b",
             tag, r, m, s, b, t, pc, id_pc, id_inst, id_valid);
  endtask

  initial begin
    rst = 1'b1; mem_ready = 1'b0; stall = 1'b0; branch_en = 1'b0; branch_target = 16'h0000;

    //  rst mr st br tgt       pc        id_pc     v  chk_id_pc
    add(1, 1, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 1);  // reset
    add(0, 1, 0, 0, 16'h0000, 16'h0001, 16'h0000, 1, 1);  // straight-line
    add(0, 1, 0, 0, 16'h0000, 16'h0002, 16'h0001, 1, 1);
    add(0, 1, 0, 0, 16'h0000, 16'h0003, 16'h0002, 1, 1);
    add(0, 0, 0, 0, 16'h0000, 16'h0003, 16'h0002, 0, 0);  // wait at 3
    add(0, 0, 0, 0, 16'h0000, 16'h0003, 16'h0002, 0, 0);
    add(0, 1, 0, 0, 16'h0000, 16'h0004, 16'h0003, 1, 1);
    add(0, 1, 0, 0, 16'h0000, 16'h0005, 16'h0004, 1, 1);
    add(0, 1, 1, 0, 16'h0000, 16'h0005, 16'h0004, 1, 1);  // stall at 5
    add(0, 0, 1, 0, 16'h0000, 16'h0005, 16'h0004, 1, 1);
    add(0, 1, 1, 0, 16'h0000, 16'h0005, 16'h0004, 1, 1);
    add(0, 1, 0, 0, 16'h0000, 16'h0006, 16'h0005, 1, 1);
    add(0, 1, 0, 0, 16'h0000, 16'h0007, 16'h0006, 1, 1);
    add(0, 1, 0, 0, 16'h0000, 16'h0008, 16'h0007, 1, 1);
    add(0, 1, 0, 0, 16'h0000, 16'h0009, 16'h0008, 1, 1);
    add(0, 1, 0, 0, 16'h0000, 16'h000A, 16'h0009, 1, 1);
    add(0, 1, 0, 0, 16'h0000, 16'h000B, 16'h000A, 1, 1);
    add(0, 1, 0, 1, 16'h0004, 16'h0004, 16'h000B, 0, 1);  // branch at 11
    add(0, 1, 0, 0, 16'h0000, 16'h0005, 16'h0004, 1, 1);
    add(0, 0, 0, 0, 16'h0000, 16'h0005, 16'h0004, 0, 0);  // enter WAIT
    add(0, 0, 1, 1, 16'h0020, 16'h0020, 16'h0005, 0, 1);  // branch in WAIT + stall
    add(0, 1, 0, 0, 16'h0000, 16'h0021, 16'h0020, 1, 1);
    add(0, 1, 0, 1, 16'hFFFF, 16'hFFFF, 16'h0021, 0, 1);
    add(0, 1, 0, 0, 16'h0000, 16'h0000, 16'hFFFF, 1, 1);  // wrap
    add(0, 0, 0, 0, 16'h0000, 16'h0000, 16'hFFFF, 0, 0);
    add(0, 1, 0, 0, 16'h0000, 16'h0001, 16'h0000, 1, 1);
    add(0, 0, 0, 0, 16'h0000, 16'h0001, 16'h0000, 0, 0);  // WAIT at 1
    add(1, 1, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 1);  // reset in WAIT
    add(0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0);  // first edge, mem not ready
    add(0, 1, 0, 0, 16'h0000, 16'h0001, 16'h0000, 1, 1);
    add(1, 1, 0, 1, 16'h0040, 16'h0000, 16'h0000, 0, 1);  // reset beats branch
    add(0, 1, 0, 0, 16'h0000, 16'h0001, 16'h0000, 1, 1);
    add(0, 1, 0, 1, 16'h0010, 16'h0010, 16'h0001, 0, 1);  // held branch
    add(0, 1, 0, 1, 16'h0030, 16'h0030, 16'h0010, 0, 1);

    foreach (vecs[i])
      step($sformatf("vec%0d", i), vecs[i].rst, vecs[i].mr, vecs[i].st, vecs[i].br,
           vecs[i].tgt, vecs[i].e_pc, vecs[i].e_id_pc, vecs[i].e_v, vecs[i].chk_id_pc);

    // WAIT held by stall even while memory turns ready, then accept.
    step("seq_wait",   0, 0, 0, 0, 16'h0000, 16'h0030, 16'h0010, 0, 0);
    step("seq_stall0", 0, 1, 1, 0, 16'h0000, 16'h0030, 16'h0010, 0, 0);
    step("seq_stall1", 0, 1, 1, 0, 16'h0000, 16'h0030, 16'h0010, 0, 0);
    step("seq_accept", 0, 1, 0, 0, 16'h0000, 16'h0031, 16'h0030, 1, 1);
    step("seq_next",   0, 1, 0, 0, 16'h0000, 16'h0032, 16'h0031, 1, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
